// File: rtl/bf16_fpu.sv
// bf16_fpu: combinational bfloat16 add/sub/mul/div with round-to-nearest-even and an overflow flag.
// Latency: 0 cycles; out_o/overflow_o are a pure function of mode_i, in1_i and in2_i.
// Backpressure: none; no handshake, the result is valid whenever the inputs are stable.
// Ports: clk/rst are present only for interface uniformity and do not affect the outputs.
//        mode_i one-hot op select (0001 add, 0010 sub, 0100 mul, 1000 div), in1_i/in2_i operands,
//        out_o bfloat16 result, overflow_o set when finite operands produce a too-large result.
module bf16_fpu (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mode_i,
    input  logic [15:0] in1_i,
    input  logic [15:0] in2_i,
    output logic [15:0] out_o,
    output logic        overflow_o
);

    localparam logic [15:0] QNAN = 16'h7FC0;

    // No state is held; clk and rst are deliberately ignored.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    // Rounds a normalized significand (leading one in mant[7]) with guard/round/sticky,
    // handles the carry-out into the exponent, then saturates to inf or flushes to zero.
    // Returns {overflow, result}.
    function automatic logic [16:0] round_pack(
        input logic               sgn,
        input logic signed [10:0] exp_in,
        input logic [7:0]         mant,
        input logic               g,
        input logic               r,
        input logic               s
    );
        logic               up;
        logic [8:0]         m9;
        logic signed [10:0] exp_r;
        logic [6:0]         frac;
        up = g & (r | s | mant[0]);
        m9 = {1'b0, mant} + {8'd0, up};
        if (m9[8]) begin
            // 1.1111111 + ulp = 10.0000000: bump exponent, fraction becomes zero
            exp_r = exp_in + 11'sd1;
            frac  = 7'd0;
        end else begin
            exp_r = exp_in;
            frac  = m9[6:0];
        end
        if (exp_r >= 11'sd255)
            round_pack = {1'b1, sgn, 8'hFF, 7'd0};
        else if (exp_r < 11'sd1)
            round_pack = {1'b0, sgn, 15'd0};
        else
            round_pack = {1'b0, sgn, exp_r[7:0], frac};
    endfunction

    // Operand decode
    logic       s1, s2;
    logic [7:0] e1, e2;
    logic [6:0] f1, f2;
    logic [7:0] m1, m2;
    logic       z1, z2, inf1, inf2, nan1, nan2;

    assign s1   = in1_i[15];
    assign s2   = in2_i[15];
    assign e1   = in1_i[14:7];
    assign e2   = in2_i[14:7];
    assign f1   = in1_i[6:0];
    assign f2   = in2_i[6:0];
    assign m1   = {1'b1, f1};
    assign m2   = {1'b1, f2};
    // exponent 0 covers both true zero and flushed subnormals
    assign z1   = (e1 == 8'h00);
    assign z2   = (e2 == 8'h00);
    assign inf1 = (e1 == 8'hFF) && (f1 == 7'd0);
    assign inf2 = (e2 == 8'hFF) && (f2 == 7'd0);
    assign nan1 = (e1 == 8'hFF) && (f1 != 7'd0);
    assign nan2 = (e2 == 8'hFF) && (f2 != 7'd0);

    logic is_add, is_sub, is_mul, is_div;
    assign is_add = (mode_i == 4'b0001);
    assign is_sub = (mode_i == 4'b0010);
    assign is_mul = (mode_i == 4'b0100);
    assign is_div = (mode_i == 4'b1000);

    // ---------------- add / sub ----------------
    logic               sb;        // effective sign of operand B
    logic               eff_sub;
    logic               swap;
    logic               sa;        // sign of the larger-magnitude operand
    logic [7:0]         ea, eb, ma, mb, d;
    logic [10:0]        a_al, b_al; // {significand, guard, round, sticky}
    logic [18:0]        b_full;
    logic [11:0]        sum;
    logic [3:0]         lz;
    logic [10:0]        norm;
    logic [7:0]         add_mant;
    logic               add_g, add_r, add_s;
    logic signed [10:0] add_exp;
    logic               add_zero;
    logic [16:0]        add_res;

    always_comb begin
        sb      = s2 ^ is_sub;
        eff_sub = s1 ^ sb;
        swap    = ({e2, f2} > {e1, f1});
        ea      = swap ? e2 : e1;
        eb      = swap ? e1 : e2;
        ma      = swap ? m2 : m1;
        mb      = swap ? m1 : m2;
        sa      = swap ? sb : s1;
        d       = ea - eb;
        a_al    = {ma, 3'b000};
        b_full  = {mb, 11'd0} >> d;
        if (d >= 8'd11)
            b_al = 11'd1;          // B lies entirely below the sticky position
        else
            b_al = {b_full[18:9], |b_full[8:0]};

        if (eff_sub)
            sum = {1'b0, a_al} - {1'b0, b_al};
        else
            sum = {1'b0, a_al} + {1'b0, b_al};
        add_zero = (sum == 12'd0);

        lz = 4'd0;
        for (int i = 0; i <= 10; i++) begin
            if (sum[i]) lz = 4'(10 - i);
        end
        norm = sum[10:0] << lz;

        if (sum[11]) begin
            // carry out of the significand add: shift right by one, fold bits into sticky
            add_mant = sum[11:4];
            add_g    = sum[3];
            add_r    = sum[2];
            add_s    = |sum[1:0];
            add_exp  = $signed({3'b000, ea}) + 11'sd1;
        end else begin
            add_mant = norm[10:3];
            add_g    = norm[2];
            add_r    = norm[1];
            add_s    = norm[0];
            add_exp  = $signed({3'b000, ea}) - $signed({7'd0, lz});
        end
        add_res = round_pack(sa, add_exp, add_mant, add_g, add_r, add_s);
    end

    // ---------------- mul ----------------
    logic [15:0]        prod;
    logic signed [10:0] mul_exp;
    logic [16:0]        mul_res;

    always_comb begin
        prod    = m1 * m2;
        mul_exp = $signed({3'b000, e1}) + $signed({3'b000, e2}) - 11'sd127;
        if (prod[15])
            mul_res = round_pack(s1 ^ s2, mul_exp + 11'sd1, prod[15:8], prod[7], prod[6], |prod[5:0]);
        else
            mul_res = round_pack(s1 ^ s2, mul_exp, prod[14:7], prod[6], prod[5], |prod[4:0]);
    end

    // ---------------- div ----------------
    // Restoring division: quo holds m1/m2 scaled by 2^11 (12 quotient bits).
    logic [9:0]         rem;
    logic [11:0]        quo;
    logic               rem_nz;
    logic signed [10:0] div_exp;
    logic [16:0]        div_res;

    always_comb begin
        rem = {2'b00, m1};
        quo = 12'd0;
        for (int i = 11; i >= 0; i--) begin
            if (rem >= {2'b00, m2}) begin
                quo[i] = 1'b1;
                rem    = rem - {2'b00, m2};
            end
            rem = rem << 1;
        end
        rem_nz  = (rem != 10'd0);
        div_exp = $signed({3'b000, e1}) - $signed({3'b000, e2}) + 11'sd127;
        if (quo[11])
            div_res = round_pack(s1 ^ s2, div_exp, quo[11:4], quo[3], quo[2], |quo[1:0] | rem_nz);
        else
            div_res = round_pack(s1 ^ s2, div_exp - 11'sd1, quo[10:3], quo[2], quo[1], quo[0] | rem_nz);
    end

    // ---------------- result select and special cases ----------------
    always_comb begin
        out_o      = 16'h0000;
        overflow_o = 1'b0;
        if (is_add || is_sub) begin
            if (nan1 || nan2)
                out_o = QNAN;
            else if (inf1 && inf2)
                out_o = (s1 != sb) ? QNAN : {s1, 8'hFF, 7'd0};
            else if (inf1)
                out_o = {s1, 8'hFF, 7'd0};
            else if (inf2)
                out_o = {sb, 8'hFF, 7'd0};
            else if (z1 && z2)
                out_o = {s1 & sb, 15'd0};
            else if (z1)
                out_o = {sb, in2_i[14:0]};
            else if (z2)
                out_o = in1_i;
            else if (add_zero)
                out_o = 16'h0000;   // exact cancellation is always +0
            else begin
                out_o      = add_res[15:0];
                overflow_o = add_res[16];
            end
        end else if (is_mul) begin
            if (nan1 || nan2 || (z1 && inf2) || (inf1 && z2))
                out_o = QNAN;
            else if (inf1 || inf2)
                out_o = {s1 ^ s2, 8'hFF, 7'd0};
            else if (z1 || z2)
                out_o = {s1 ^ s2, 15'd0};
            else begin
                out_o      = mul_res[15:0];
                overflow_o = mul_res[16];
            end
        end else if (is_div) begin
            if (nan1 || nan2 || (z1 && z2) || (inf1 && inf2))
                out_o = QNAN;
            else if (inf1 || z2)
                out_o = {s1 ^ s2, 8'hFF, 7'd0};
            else if (inf2 || z1)
                out_o = {s1 ^ s2, 15'd0};
            else begin
                out_o      = div_res[15:0];
                overflow_o = div_res[16];
            end
        end
    end

endmodule

// File: tb/tb_bf16_fpu.sv
// tb_bf16_fpu: directed vector table, reset-independence sequence and random vectors
// checked against a real-arithmetic bfloat16 reference model.
module tb_bf16_fpu;

    logic        clk;
    logic        rst;
    logic [3:0]  mode;
    logic [15:0] in1, in2;
    logic [15:0] out;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    bf16_fpu dut (
        .clk        (clk),
        .rst        (rst),
        .mode_i     (mode),
        .in1_i      (in1),
        .in2_i      (in2),
        .out_o      (out),
        .overflow_o (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] eout;
        logic        eovf;
    } vec_t;

    localparam int NVEC = 33;
    vec_t vtab [NVEC];

    // ---------------- reference model ----------------
    function automatic real pow2(input int n);
        real v;
        v = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) v = v * 2.0;
        else        for (int i = 0; i < -n; i++) v = v / 2.0;
        return v;
    endfunction

    function automatic real bf_val(input logic [15:0] x);
        int  ei, fi;
        real v;
        ei = int'(x[14:7]);
        fi = int'(x[6:0]);
        if (ei == 0) return 0.0;
        v = (128.0 + fi) / 128.0 * pow2(ei - 127);
        return x[15] ? -v : v;
    endfunction

    // Round an exact (or sufficiently precise) real to bfloat16, RNE. Returns {ovf, value}.
    function automatic logic [16:0] ref_round(input real r);
        logic sgn;
        real  m, fr;
        int   e, i, be;
        if (r == 0.0) return 17'h00000;
        sgn = (r < 0.0);
        m   = sgn ? -r : r;
        e   = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        i  = $rtoi(m * 128.0);
        fr = m * 128.0 - i;
        if (fr > 0.5 || (fr == 0.5 && (i % 2) == 1)) i++;
        if (i == 256) begin i = 128; e++; end
        be = e + 127;
        if (be >= 255) return {1'b1, sgn, 8'hFF, 7'h00};
        if (be < 1)    return {1'b0, sgn, 15'h0000};
        return {1'b0, sgn, be[7:0], i[6:0]};
    endfunction

    function automatic logic [16:0] ref_model(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
        logic sa, sb, sp;
        bit   za, zb, ia, ib, na, nb;
        real  va, vb;
        if (!(m == 4'b0001 || m == 4'b0010 || m == 4'b0100 || m == 4'b1000)) return 17'h00000;
        za = (a[14:7] == 8'h00);
        zb = (b[14:7] == 8'h00);
        ia = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
        ib = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
        na = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
        nb = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);
        if (na || nb) return {1'b0, 16'h7FC0};
        sa = a[15];
        sb = b[15];
        sp = sa ^ sb;
        va = bf_val(a);
        vb = bf_val(b);
        if (m == 4'b0001 || m == 4'b0010) begin
            if (m == 4'b0010) begin sb = ~sb; vb = -vb; end
            if (ia && ib) return (sa != sb) ? {1'b0, 16'h7FC0} : {1'b0, sa, 8'hFF, 7'h00};
            if (ia)       return {1'b0, sa, 8'hFF, 7'h00};
            if (ib)       return {1'b0, sb, 8'hFF, 7'h00};
            if (za && zb) return {1'b0, sa & sb, 15'h0000};
            return ref_round(va + vb);
        end else if (m == 4'b0100) begin
            if ((za && ib) || (ia && zb)) return {1'b0, 16'h7FC0};
            if (ia || ib) return {1'b0, sp, 8'hFF, 7'h00};
            if (za || zb) return {1'b0, sp, 15'h0000};
            return ref_round(va * vb);
        end else begin
            if ((za && zb) || (ia && ib)) return {1'b0, 16'h7FC0};
            if (ia || zb) return {1'b0, sp, 8'hFF, 7'h00};
            if (ib || za) return {1'b0, sp, 15'h0000};
            return ref_round(va / vb);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] rand_op(input int near_e, input bit use_near);
        int         cls, t, e;
        logic       sgn;
        logic [6:0] f7;
        cls = int'($urandom_range(0, 19));
        t   = int'($urandom_range(0, 1));
        sgn = t[0];
        t   = int'($urandom_range(0, 127));
        f7  = t[6:0];
        if (cls == 0) return {sgn, 8'h00, f7};                 // zero or flushed subnormal
        if (cls == 1) return {sgn, 8'hFF, 7'h00};              // infinity
        if (cls == 2) return {sgn, 8'hFF, (f7 == 7'h00) ? 7'h01 : f7};
        if (use_near) e = near_e + int'($urandom_range(0, 24)) - 12;
        else          e = int'($urandom_range(1, 254));
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        return {sgn, e[7:0], f7};
    endfunction

    task automatic check(input string name, input logic [15:0] eout, input logic eovf);
        checks++;
        if (out !== eout || ovf !== eovf) begin
            failures++;
            $display("FAIL %s: mode=%b in1=%h in2=%h got out=%h ovf=%b, expected out=%h ovf=%b",
                     name, mode, in1, in2, out, ovf, eout, eovf);
        end
    endtask

    // Called on a falling edge: drive inputs, then check on the next falling edge.
    task automatic apply_check(input string name, input logic [3:0] m, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] eout, input logic eovf);
        mode = m;
        in1  = a;
        in2  = b;
        @(negedge clk);
        check(name, eout, eovf);
    endtask

    initial begin
        logic [16:0] exp_r;
        logic [3:0]  m;
        logic [15:0] a, b;
        int          t;

        vtab[0]  = '{4'b0001, 16'h3F80, 16'h4000, 16'h4040, 1'b0};
        vtab[1]  = '{4'b0010, 16'h3F80, 16'h4000, 16'hBF80, 1'b0};
        vtab[2]  = '{4'b0010, 16'h3F80, 16'h3F80, 16'h0000, 1'b0};
        vtab[3]  = '{4'b0100, 16'h4000, 16'h4040, 16'h40C0, 1'b0};
        vtab[4]  = '{4'b0100, 16'h7F00, 16'h4000, 16'h7F80, 1'b1};
        vtab[5]  = '{4'b1000, 16'h3F80, 16'h4040, 16'h3EAB, 1'b0};
        vtab[6]  = '{4'b1000, 16'h3F80, 16'h0000, 16'h7F80, 1'b0};
        vtab[7]  = '{4'b0001, 16'h3F80, 16'h3B80, 16'h3F80, 1'b0};
        vtab[8]  = '{4'b0001, 16'h3F81, 16'h3B80, 16'h3F82, 1'b0};
        vtab[9]  = '{4'b0001, 16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0};
        vtab[10] = '{4'b0100, 16'h3F80, 16'h7FC1, 16'h7FC0, 1'b0};
        vtab[11] = '{4'b1000, 16'h7FC1, 16'h7FC1, 16'h7FC0, 1'b0};
        vtab[12] = '{4'b0011, 16'h3F80, 16'h4000, 16'h0000, 1'b0};
        vtab[13] = '{4'b0001, 16'h3FFF, 16'h3B80, 16'h4000, 1'b0};
        vtab[14] = '{4'b0001, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0};
        vtab[15] = '{4'b0010, 16'h7F80, 16'h7F80, 16'h7FC0, 1'b0};
        vtab[16] = '{4'b0100, 16'h0000, 16'h7F80, 16'h7FC0, 1'b0};
        vtab[17] = '{4'b1000, 16'h0000, 16'h0000, 16'h7FC0, 1'b0};
        vtab[18] = '{4'b1000, 16'h7F80, 16'hFF80, 16'h7FC0, 1'b0};
        vtab[19] = '{4'b1000, 16'h8000, 16'h3F80, 16'h8000, 1'b0};
        vtab[20] = '{4'b1000, 16'h3F80, 16'hFF80, 16'h8000, 1'b0};
        vtab[21] = '{4'b0100, 16'h0080, 16'h0080, 16'h0000, 1'b0};
        vtab[22] = '{4'b0100, 16'h8080, 16'h0080, 16'h8000, 1'b0};
        vtab[23] = '{4'b0001, 16'hFF80, 16'h3F80, 16'hFF80, 1'b0};
        vtab[24] = '{4'b0001, 16'h7F7F, 16'h7F7F, 16'h7F80, 1'b1};
        vtab[25] = '{4'b1000, 16'h7F00, 16'h3F00, 16'h7F80, 1'b1};
        vtab[26] = '{4'b1000, 16'hBF80, 16'h0000, 16'hFF80, 1'b0};
        vtab[27] = '{4'b0010, 16'h3F80, 16'hBF80, 16'h4000, 1'b0};
        vtab[28] = '{4'b0001, 16'h0001, 16'h3F80, 16'h3F80, 1'b0};
        vtab[29] = '{4'b0000, 16'h3F80, 16'h3F80, 16'h0000, 1'b0};
        vtab[30] = '{4'b0010, 16'h3F80, 16'h3F7F, 16'h3B80, 1'b0};
        vtab[31] = '{4'b0100, 16'h3F81, 16'h3F81, 16'h3F82, 1'b0};
        vtab[32] = '{4'b0100, 16'h3FFF, 16'h3FFF, 16'h407E, 1'b0};

        rst  = 1'b1;
        mode = 4'b0001;
        in1  = 16'h3F80;
        in2  = 16'h4000;
        @(negedge clk);

        // Outputs while reset is held are just the combinational result.
        apply_check("reset_add", 4'b0001, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++)
            apply_check($sformatf("vec%0d", i), vtab[i].mode, vtab[i].a, vtab[i].b,
                        vtab[i].eout, vtab[i].eovf);

        // Reset toggled mid-cycle must not disturb the result.
        mode = 4'b0100; in1 = 16'h4000; in2 = 16'h4040;
        @(posedge clk); rst = 1'b1;
        @(negedge clk); check("rst_rise_mul", 16'h40C0, 1'b0);
        mode = 4'b1000; in1 = 16'h3F80; in2 = 16'h4040;
        @(posedge clk); rst = 1'b0;
        @(negedge clk); check("rst_fall_div", 16'h3EAB, 1'b0);
        mode = 4'b0100; in1 = 16'h7F00; in2 = 16'h4000;
        @(posedge clk); rst = 1'b1;
        @(posedge clk); rst = 1'b0;
        @(negedge clk); check("rst_pulse_ovf", 16'h7F80, 1'b1);

        // Random vectors against the reference model; rst is randomized to show it is ignored.
        for (int n = 0; n < 3000; n++) begin
            t = int'($urandom_range(0, 9));
            if (t == 0) begin
                t = int'($urandom_range(0, 15));
                m = t[3:0];
            end else begin
                m = 4'b0001 << $urandom_range(0, 3);
            end
            a = rand_op(0, 1'b0);
            t = int'($urandom_range(0, 1));
            b = rand_op(int'(a[14:7]), (m == 4'b0001 || m == 4'b0010) && t == 1);
            t = int'($urandom_range(0, 1));
            rst   = t[0];
            exp_r = ref_model(m, a, b);
            apply_check("rand", m, a, b, exp_r[15:0], exp_r[16]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
